// File: rtl/axi_full_master.sv
// Single-outstanding AXI4 master: CPU/cache requests become INCR read bursts (1..256 beats)
// or single-beat strobed writes; one response pulse per read beat or per completed write.
module axi_full_master #(
   parameter int unsigned BUS_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [3:0]  AXI_ID     = 4'h0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [BUS_WIDTH-1:0]    req_addr,
   input  logic [7:0]              req_len,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   output logic                    resp_valid,
   output logic [DATA_WIDTH-1:0]   resp_data,
   output logic                    resp_last,
   output logic                    resp_err,
   output logic                    ar_valid,
   input  logic                    ar_ready,
   output logic [3:0]              ar_id,
   output logic [7:0]              ar_len,
   output logic [2:0]              ar_size,
   output logic [BUS_WIDTH-1:0]    ar_addr,
   output logic [2:0]              ar_prot,
   output logic [1:0]              ar_burst,
   output logic [1:0]              ar_lock,
   output logic [3:0]              ar_cache,
   output logic                    aw_valid,
   input  logic                    aw_ready,
   output logic [3:0]              aw_id,
   output logic [7:0]              aw_len,
   output logic [2:0]              aw_size,
   output logic [BUS_WIDTH-1:0]    aw_addr,
   output logic [2:0]              aw_prot,
   output logic [1:0]              aw_burst,
   output logic [1:0]              aw_lock,
   output logic [3:0]              aw_cache,
   input  logic                    rd_valid,
   output logic                    rd_ready,
   input  logic [3:0]              rd_id,
   input  logic [DATA_WIDTH-1:0]   rd_data,
   input  logic [1:0]              rd_resp,
   input  logic                    rd_last,
   output logic                    wd_valid,
   input  logic                    wd_ready,
   output logic [3:0]              wd_id,
   output logic [DATA_WIDTH-1:0]   wd_data,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wd_last,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [3:0]              wr_id,
   input  logic [1:0]              wr_breap
);

   typedef enum logic [2:0] {S_IDLE, S_AR, S_RDATA, S_WRITE, S_BRESP} state_t;

   state_t     r_state;
   logic [7:0] r_cnt;
   logic       r_err;

   logic w_cnt_end;
   logic w_beat_done;
   logic w_beat_err;
   logic w_aw_done;
   logic w_wd_done;
   logic w_unused;

   // Fixed attributes: 4-byte INCR beats, normal access, single write beat
   assign ar_id    = AXI_ID;
   assign ar_size  = 3'b010;
   assign ar_burst = 2'b01;
   assign ar_lock  = 2'b00;
   assign ar_cache = 4'h0;
   assign ar_prot  = 3'b000;
   assign aw_id    = AXI_ID;
   assign aw_len   = 8'd0;
   assign aw_size  = 3'b010;
   assign aw_burst = 2'b01;
   assign aw_lock  = 2'b00;
   assign aw_cache = 4'h0;
   assign aw_prot  = 3'b000;
   assign wd_id    = AXI_ID;

   // Burst ends on rd_last or on the expected count; disagreement between the two is an error
   assign w_cnt_end   = (r_cnt == ar_len);
   assign w_beat_done = rd_last || w_cnt_end;
   assign w_beat_err  = (rd_resp != 2'b00) || (rd_last != w_cnt_end);
   assign w_aw_done   = !aw_valid || aw_ready;
   assign w_wd_done   = !wd_valid || wd_ready;

   // IDs are irrelevant with a single transaction outstanding
   assign w_unused = &{1'b0, rd_id, wr_id};

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= 8'd0;
         r_err      <= 1'b0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_last  <= 1'b0;
         resp_err   <= 1'b0;
         ar_valid   <= 1'b0;
         ar_addr    <= '0;
         ar_len     <= 8'd0;
         aw_valid   <= 1'b0;
         aw_addr    <= '0;
         wd_valid   <= 1'b0;
         wd_data    <= '0;
         wstrb      <= '0;
         wd_last    <= 1'b0;
         rd_ready   <= 1'b0;
         wr_ready   <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_last  <= 1'b0;
         resp_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  r_cnt     <= 8'd0;
                  r_err     <= 1'b0;
                  if (req_we) begin
                     aw_valid <= 1'b1;
                     aw_addr  <= req_addr;
                     wd_valid <= 1'b1;
                     wd_data  <= req_wdata;
                     wstrb    <= req_wstrb;
                     wd_last  <= 1'b1;
                     r_state  <= S_WRITE;
                  end else begin
                     ar_valid <= 1'b1;
                     ar_addr  <= req_addr;
                     ar_len   <= req_len;
                     r_state  <= S_AR;
                  end
               end
            end
            S_AR: begin
               if (ar_ready) begin
                  ar_valid <= 1'b0;
                  rd_ready <= 1'b1;
                  r_state  <= S_RDATA;
               end
            end
            S_RDATA: begin
               if (rd_valid) begin
                  resp_valid <= 1'b1;
                  resp_data  <= rd_data;
                  r_cnt      <= r_cnt + 8'd1;
                  r_err      <= r_err | w_beat_err;
                  if (w_beat_done) begin
                     resp_last <= 1'b1;
                     resp_err  <= r_err | w_beat_err;
                     rd_ready  <= 1'b0;
                     req_ready <= 1'b1;
                     r_state   <= S_IDLE;
                  end
               end
            end
            S_WRITE: begin
               if (aw_ready) aw_valid <= 1'b0;
               if (wd_ready) begin
                  wd_valid <= 1'b0;
                  wd_last  <= 1'b0;
               end
               if (w_aw_done && w_wd_done) begin
                  wr_ready <= 1'b1;
                  r_state  <= S_BRESP;
               end
            end
            S_BRESP: begin
               if (wr_valid) begin
                  wr_ready   <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_last  <= 1'b1;
                  resp_err   <= (wr_breap != 2'b00);
                  req_ready  <= 1'b1;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_full_master.sv
// Bench for axi_full_master: table vectors, hand-written reset/back-to-back sequences and
// randomized transactions against a transaction-level model of the expected responses.
module tb_axi_full_master;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [7:0]    req_len;
   logic [DW-1:0] req_wdata;
   logic [3:0]    req_wstrb;
   logic          resp_valid, resp_last, resp_err;
   logic [DW-1:0] resp_data;
   logic          ar_valid, ar_ready;
   logic [3:0]    ar_id, ar_cache;
   logic [7:0]    ar_len;
   logic [2:0]    ar_size, ar_prot;
   logic [AW-1:0] ar_addr;
   logic [1:0]    ar_burst, ar_lock;
   logic          aw_valid, aw_ready;
   logic [3:0]    aw_id, aw_cache;
   logic [7:0]    aw_len;
   logic [2:0]    aw_size, aw_prot;
   logic [AW-1:0] aw_addr;
   logic [1:0]    aw_burst, aw_lock;
   logic          rd_valid, rd_ready, rd_last;
   logic [3:0]    rd_id;
   logic [DW-1:0] rd_data;
   logic [1:0]    rd_resp;
   logic          wd_valid, wd_ready, wd_last;
   logic [3:0]    wd_id, wstrb;
   logic [DW-1:0] wd_data;
   logic          wr_valid, wr_ready;
   logic [3:0]    wr_id;
   logic [1:0]    wr_breap;

   always #5 clk = ~clk;

   axi_full_master #(.BUS_WIDTH(AW), .DATA_WIDTH(DW), .AXI_ID(4'h0)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
      .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last), .resp_err(resp_err),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_len(ar_len), .ar_size(ar_size),
      .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_burst(ar_burst), .ar_lock(ar_lock), .ar_cache(ar_cache),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_len(aw_len), .aw_size(aw_size),
      .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_burst(aw_burst), .aw_lock(aw_lock), .aw_cache(aw_cache),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_id(rd_id), .rd_data(rd_data), .rd_resp(rd_resp),
      .rd_last(rd_last),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_id(wd_id), .wd_data(wd_data), .wstrb(wstrb),
      .wd_last(wd_last),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_id(wr_id), .wr_breap(wr_breap)
   );

   // One transaction: request fields, slave behaviour, and (optionally) hand-derived expectations
   typedef struct {
      bit          we;
      logic [31:0] addr;
      int          len;
      int          last_at;   // beat carrying rd_last; > len means never
      int          err_beat;  // beat with SLVERR; -1 means none
      logic [31:0] base;      // write data, or read data of beat 0
      logic [3:0]  strb;
      logic [1:0]  bresp;
      int          dly;       // ar_ready / aw_ready delay
      int          dly2;      // wd_ready delay
      int          gap;       // max rd_valid gap / B delay
      int          exp_n;
      bit          exp_err;
      bit          use_exp;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic        last;
      logic        err;
   } rsp_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   rsp_t obs_q[$];
   rsp_t exp_q[$];

   function automatic vec_t mk(bit we, logic [31:0] addr, int len, int last_at, int err_beat,
                               logic [31:0] base, logic [3:0] strb, logic [1:0] bresp,
                               int dly, int dly2, int gap, int exp_n, bit exp_err);
      vec_t v;
      v.we = we; v.addr = addr; v.len = len; v.last_at = last_at; v.err_beat = err_beat;
      v.base = base; v.strb = strb; v.bresp = bresp; v.dly = dly; v.dly2 = dly2; v.gap = gap;
      v.exp_n = exp_n; v.exp_err = exp_err; v.use_exp = 1'b1;
      return v;
   endfunction

   function automatic logic [31:0] beat_data(logic [31:0] base, int i);
      return base + 32'(i) * 32'h0101_0101;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one cycle; collect responses and enforce hold/overlap rules on the AXI outputs
   task automatic step();
      bit          rs, pa, pw, pd;
      logic [39:0] sa;
      logic [31:0] sw;
      logic [35:0] sd;
      rs = reset;
      pa = (ar_valid === 1'b1) && !ar_ready;
      pw = (aw_valid === 1'b1) && !aw_ready;
      pd = (wd_valid === 1'b1) && !wd_ready;
      sa = {ar_addr, ar_len};
      sw = aw_addr;
      sd = {wd_data, wstrb};
      @(posedge clk);
      #1;
      if (resp_valid === 1'b1) obs_q.push_back('{resp_data, resp_last, resp_err});
      if (rs && pa) check("ar_hold", {ar_valid, ar_addr, ar_len}, {1'b1, sa});
      if (rs && pw) check("aw_hold", {aw_valid, aw_addr}, {1'b1, sw});
      if (rs && pd) check("wd_hold", {wd_valid, wd_data, wstrb}, {1'b1, sd});
      if (ar_valid || rd_ready) check("no_overlap", aw_valid | wd_valid | wr_ready, 1'b0);
   endtask

   task automatic wait_req_ready(output int cyc);
      cyc = 0;
      while (!req_ready && cyc < 300) begin
         step();
         cyc++;
      end
      check("req_ready_wait", req_ready, 1'b1);
   endtask

   task automatic compare_resp(input vec_t v);
      int n;
      check("resp_count", obs_q.size(), exp_q.size());
      if (v.use_exp) check("tab_count", obs_q.size(), v.exp_n);
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check("resp_data", obs_q[i].d, exp_q[i].d);
         check("resp_last", obs_q[i].last, exp_q[i].last);
         check("resp_err", obs_q[i].err, exp_q[i].err);
      end
      if (v.use_exp && obs_q.size() > 0) check("tab_err", obs_q[obs_q.size()-1].err, v.exp_err);
      check("req_ready_back", req_ready, 1'b1);
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic run_read(input vec_t v, input bit hold, input vec_t nx);
      int n, cyc, ng;
      bit e;
      check("stray_resp", obs_q.size(), 0);
      obs_q.delete();
      n = ((v.last_at < v.len) ? v.last_at : v.len) + 1;
      e = (v.err_beat >= 0 && v.err_beat < n) || (v.last_at != v.len);
      for (int i = 0; i < n; i++)
         exp_q.push_back('{beat_data(v.base, i), (i == n-1), (i == n-1) && e});
      req_valid = 1'b1; req_we = 1'b0; req_addr = v.addr; req_len = 8'(v.len);
      wait_req_ready(cyc);
      step();
      if (hold) begin
         req_we = 1'b1; req_addr = nx.addr; req_wdata = nx.base; req_wstrb = nx.strb;
      end else begin
         req_valid = 1'b0;
      end
      check("ar_valid", ar_valid, 1'b1);
      check("ar_fields", {ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_id},
            {v.addr, 8'(v.len), 3'b010, 2'b01, 2'b00, 4'h0, 3'b000, 4'h0});
      for (int k = 0; k < v.dly; k++) step();
      ar_ready = 1'b1;
      step();
      ar_ready = 1'b0;
      check("ar_dropped", ar_valid, 1'b0);
      for (int i = 0; i < n; i++) begin
         ng = int'($urandom % 32'(v.gap + 1));
         for (int g = 0; g < ng; g++) step();
         rd_valid = 1'b1;
         rd_data  = beat_data(v.base, i);
         rd_resp  = (i == v.err_beat) ? 2'b10 : 2'b00;
         rd_last  = (i == v.last_at);
         cyc = 0;
         while (!rd_ready && cyc < 50) begin
            step();
            cyc++;
         end
         check("rd_ready", rd_ready, 1'b1);
         step();
         rd_valid = 1'b0; rd_last = 1'b0; rd_resp = 2'b00;
      end
      compare_resp(v);
   endtask

   task automatic run_write(input vec_t v, output int wait_cyc);
      bit aw_done, wd_done, hs_aw, hs_wd;
      int t, cyc;
      check("stray_resp", obs_q.size(), 0);
      obs_q.delete();
      exp_q.push_back('{32'h0, 1'b1, (v.bresp != 2'b00)});
      req_valid = 1'b1; req_we = 1'b1; req_addr = v.addr; req_wdata = v.base; req_wstrb = v.strb;
      wait_req_ready(wait_cyc);
      step();
      req_valid = 1'b0;
      aw_done = 1'b0; wd_done = 1'b0; t = 0;
      while (!(aw_done && wd_done) && t < 100) begin
         check("aw_valid", aw_valid, !aw_done);
         check("wd_valid", wd_valid, !wd_done);
         if (!aw_done)
            check("aw_fields", {aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_id},
                  {v.addr, 8'd0, 3'b010, 2'b01, 2'b00, 4'h0, 3'b000, 4'h0});
         if (!wd_done)
            check("wd_fields", {wd_data, wstrb, wd_last, wd_id}, {v.base, v.strb, 1'b1, 4'h0});
         aw_ready = !aw_done && (t >= v.dly);
         wd_ready = !wd_done && (t >= v.dly2);
         hs_aw = aw_ready && aw_valid;
         hs_wd = wd_ready && wd_valid;
         step();
         t++;
         aw_ready = 1'b0; wd_ready = 1'b0;
         aw_done |= hs_aw;
         wd_done |= hs_wd;
      end
      check("w_handshakes", {aw_done, wd_done}, 2'b11);
      check("w_valids_off", {aw_valid, wd_valid}, 2'b00);
      for (int k = 0; k < v.gap; k++) step();
      wr_valid = 1'b1; wr_breap = v.bresp;
      cyc = 0;
      while (!wr_ready && cyc < 50) begin
         step();
         cyc++;
      end
      check("wr_ready", wr_ready, 1'b1);
      step();
      wr_valid = 1'b0; wr_breap = 2'b00;
      compare_resp(v);
   endtask

   vec_t tab[9];
   vec_t rv, wv;
   int   wc;

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
      req_wdata = '0; req_wstrb = '0; ar_ready = 1'b0; aw_ready = 1'b0; wd_ready = 1'b0;
      rd_valid = 1'b0; rd_id = '0; rd_data = '0; rd_resp = '0; rd_last = 1'b0;
      wr_valid = 1'b0; wr_id = '0; wr_breap = '0;

      //           we addr           len last err  base          strb    br  d  d2 gap  n  err
      tab[0] = mk(0, 32'h8000_0000, 0,   0,  -1, 32'h1234_5678, 4'h0,   0, 0, 0, 0,   1,  0);
      tab[1] = mk(0, 32'h8000_0100, 3,   3,  -1, 32'hA000_0000, 4'h0,   0, 3, 0, 2,   4,  0);
      tab[2] = mk(1, 32'h8000_0010, 0,   0,  -1, 32'hAABB_CCDD, 4'b0101, 0, 2, 0, 1,  1,  0);
      tab[3] = mk(0, 32'h8000_0200, 3,   1,  -1, 32'h5555_0000, 4'h0,   0, 0, 0, 0,   2,  1);
      tab[4] = mk(0, 32'h8000_0300, 2,   9,  -1, 32'h0BAD_F00D, 4'h0,   0, 1, 0, 1,   3,  1);
      tab[5] = mk(0, 32'h8000_0400, 1,   1,   0, 32'h7777_0000, 4'h0,   0, 0, 0, 0,   2,  1);
      tab[6] = mk(1, 32'h8000_0020, 0,   0,  -1, 32'h0102_0304, 4'hF,   2, 0, 3, 0,   1,  1);
      tab[7] = mk(1, 32'h8000_0030, 0,   0,  -1, 32'hDEAD_BEEF, 4'b1000, 0, 0, 0, 2,  1,  0);
      tab[8] = mk(0, 32'h8001_0000, 255, 255, -1, 32'h0000_1000, 4'h0,   0, 0, 0, 0, 256,  0);

      for (int k = 0; k < 3; k++) step();
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_ctrl", {ar_valid, aw_valid, wd_valid, rd_ready, wr_ready, resp_valid, resp_last, resp_err}, 8'h00);
      check("rst_ar_addr", ar_addr, 32'h0);
      check("rst_aw_addr", aw_addr, 32'h0);
      check("rst_wd_data", {wd_data, wstrb}, 36'h0);
      check("rst_resp_data", resp_data, 32'h0);
      reset = 1'b1;
      step();
      check("req_ready_after_rst", req_ready, 1'b1);

      foreach (tab[i]) begin
         if (tab[i].we) run_write(tab[i], wc);
         else           run_read(tab[i], 1'b0, tab[i]);
      end

      // Reset while the second beat of a burst is being presented
      check("stray_resp", obs_q.size(), 0);
      obs_q.delete();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0500; req_len = 8'd3;
      wait_req_ready(wc);
      step();
      req_valid = 1'b0;
      ar_ready = 1'b1;
      step();
      ar_ready = 1'b0;
      rd_valid = 1'b1; rd_data = 32'hCAFE_0000; rd_resp = 2'b00; rd_last = 1'b0;
      step();
      check("rst_seq_beat0", {obs_q.size() == 1, (obs_q.size() > 0) ? obs_q[0].d : 32'h0},
            {1'b1, 32'hCAFE_0000});
      rd_data = 32'hCAFE_0001;
      reset = 1'b0;
      step();
      check("midrst_ctrl", {ar_valid, aw_valid, wd_valid, rd_ready, wr_ready, resp_valid, req_ready}, 7'h00);
      check("midrst_no_resp", obs_q.size(), 1);
      obs_q.delete();
      rd_valid = 1'b0;
      reset = 1'b1;
      step();
      check("midrst_req_ready", req_ready, 1'b1);
      run_read(mk(0, 32'h8000_0600, 1, 1, -1, 32'h3C3C_0000, 4'h0, 0, 1, 0, 1, 2, 0), 1'b0, tab[0]);

      // Back-to-back read then write with req_valid held high
      rv = mk(0, 32'h8000_0700, 1, 1, -1, 32'h1111_2222, 4'h0, 0, 0, 0, 0, 2, 0);
      wv = mk(1, 32'h8000_0704, 0, 0, -1, 32'h3333_4444, 4'b0011, 0, 1, 1, 0, 1, 0);
      run_read(rv, 1'b1, wv);
      run_write(wv, wc);
      check("b2b_accept_wait", wc, 0);

      for (int r = 0; r < 40; r++) begin
         vec_t v;
         v.we       = ($urandom_range(1, 0) == 1);
         v.addr     = 32'h8000_0000 | ($urandom & 32'h000F_FFFC);
         v.len      = int'($urandom_range(15, 0));
         v.last_at  = ($urandom_range(9, 0) < 7) ? v.len : int'($urandom_range(32'(v.len + 2), 0));
         v.err_beat = ($urandom_range(4, 0) == 0) ? int'($urandom_range(32'(v.len), 0)) : -1;
         v.base     = $urandom;
         v.strb     = 4'($urandom_range(15, 0));
         v.bresp    = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
         v.dly      = int'($urandom_range(3, 0));
         v.dly2     = int'($urandom_range(3, 0));
         v.gap      = int'($urandom_range(2, 0));
         v.exp_n    = 0;
         v.exp_err  = 1'b0;
         v.use_exp  = 1'b0;
         if (v.we) run_write(v, wc);
         else      run_read(v, 1'b0, v);
      end

      step();
      check("final_stray_resp", obs_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
